// File: rtl/blwl_prog_pkg.sv
// Shared types and default parameters for the BL/WL programming controller.
package blwl_prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SETUP,
        PULSE,
        HOLD
    } state_e;

    localparam int DEF_NUM_ROWS        = 16;
    localparam int DEF_NUM_COLS        = 16;
    localparam int DEF_SETUP_CYCLES    = 1;
    localparam int DEF_WL_PULSE_CYCLES = 2;
    localparam int DEF_CLR_CYCLES      = 2;

    // Sizes the shared cycle-down counter to the longest timed phase.
    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/blwl_row_decoder.sv
// Registered one-hot word-line decoder; output is all-zero whenever enable is low.
module blwl_row_decoder
    import blwl_prog_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [ROW_W-1:0]    row_i,
    output logic [NUM_ROWS-1:0] wl_o
);

    logic [NUM_ROWS-1:0] wl_d;
    logic [NUM_ROWS-1:0] wl_q;

    always_comb begin
        wl_d = '0;
        if (en_i) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                wl_d[i] = (row_i == ROW_W'(i));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wl_q <= '0;
        end else begin
            wl_q <= wl_d;
        end
    end

    assign wl_o = wl_q;

endmodule

// File: rtl/blwl_prog_ctrl.sv
// Programming controller: accepts row words and sequences BL setup, a one-hot WL pulse and BL hold,
// plus an array-wide clear through the cells' reset pin.
module blwl_prog_ctrl
    import blwl_prog_pkg::*;
#(
    parameter int NUM_ROWS        = DEF_NUM_ROWS,
    parameter int NUM_COLS        = DEF_NUM_COLS,
    parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int WL_PULSE_CYCLES = DEF_WL_PULSE_CYCLES,
    parameter int CLR_CYCLES      = DEF_CLR_CYCLES,
    localparam int ROW_W          = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                prog_clk,
    input  logic                reset_n,
    input  logic                clr_req,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [ROW_W-1:0]    cfg_row,
    input  logic [NUM_COLS-1:0] cfg_data,
    output logic [NUM_COLS-1:0] bl,
    output logic [NUM_ROWS-1:0] wl,
    output logic                sram_reset,
    output logic                busy,
    output logic                err,
    output logic [ROW_W:0]      rows_done
);

    localparam int CNT_W = $clog2(maxOf3(SETUP_CYCLES, WL_PULSE_CYCLES, CLR_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WL_PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLR_CYCLES);
    localparam logic [ROW_W:0]   ROW_LIMIT  = (ROW_W + 1)'(NUM_ROWS);
    localparam logic [ROW_W:0]   DONE_MAX   = '1;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ROW_W-1:0]    row_q;
    logic [NUM_COLS-1:0] bl_q;
    logic                sramReset_q;
    logic                err_q;
    logic [ROW_W:0]      rowsDone_q;

    logic rowInRange;
    logic wlEn_d;

    assign rowInRange = ({1'b0, cfg_row} < ROW_LIMIT);

    // The decoder registers its output, so it is fed the enable for the coming cycle.
    always_comb begin
        wlEn_d = 1'b0;
        case (state_q)
            SETUP:   wlEn_d = (cnt_q == CNT_ONE);
            PULSE:   wlEn_d = (cnt_q != CNT_ONE);
            default: wlEn_d = 1'b0;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            bl_q        <= '0;
            sramReset_q <= 1'b0;
            err_q       <= 1'b0;
            rowsDone_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Clear takes priority; a word offered alongside it is left pending.
                    if (clr_req) begin
                        state_q     <= CLR;
                        cnt_q       <= CLR_LOAD;
                        sramReset_q <= 1'b1;
                        rowsDone_q  <= '0;
                    end else if (cfg_valid) begin
                        if (rowInRange) begin
                            state_q <= SETUP;
                            cnt_q   <= SETUP_LOAD;
                            row_q   <= cfg_row;
                            bl_q    <= cfg_data;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                CLR: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        sramReset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q <= PULSE;
                        cnt_q   <= PULSE_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q <= HOLD;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    bl_q    <= '0;
                    if (rowsDone_q != DONE_MAX) begin
                        rowsDone_q <= rowsDone_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    bl_q    <= '0;
                end
            endcase
        end
    end

    blwl_row_decoder #(
        .NUM_ROWS(NUM_ROWS),
        .ROW_W   (ROW_W)
    ) u_row_decoder (
        .clk_i (prog_clk),
        .rst_ni(reset_n),
        .en_i  (wlEn_d),
        .row_i (row_q),
        .wl_o  (wl)
    );

    assign cfg_ready  = (state_q == IDLE) && !clr_req;
    assign busy       = (state_q != IDLE);
    assign bl         = bl_q;
    assign sram_reset = sramReset_q;
    assign err        = err_q;
    assign rows_done  = rowsDone_q;

endmodule

// File: tb/tb_blwl_prog_ctrl.sv
// Directed testbench for blwl_prog_ctrl: 4x4 array instance plus a 3-row instance for out-of-range rows.
module tb_blwl_prog_ctrl;

    logic       clk;
    logic       resetN;
    logic       clrReq;
    logic       cfgValid;
    logic [1:0] cfgRow;
    logic [3:0] cfgData;
    logic       cfgReady;
    logic [3:0] bl;
    logic [3:0] wl;
    logic       sramReset;
    logic       busy;
    logic       err;
    logic [2:0] rowsDone;

    logic       cfgValid3;
    logic [1:0] cfgRow3;
    logic       cfgReady3;
    logic [3:0] bl3;
    logic [2:0] wl3;
    logic       sramReset3;
    logic       busy3;
    logic       err3;
    logic [2:0] rowsDone3;

    int checks = 0;
    int errors = 0;

    logic [3:0] prevBl = '0;
    logic [3:0] rowData [4];

    blwl_prog_ctrl #(
        .NUM_ROWS(4), .NUM_COLS(4), .SETUP_CYCLES(1), .WL_PULSE_CYCLES(2), .CLR_CYCLES(2)
    ) dut (
        .prog_clk  (clk),
        .reset_n   (resetN),
        .clr_req   (clrReq),
        .cfg_valid (cfgValid),
        .cfg_ready (cfgReady),
        .cfg_row   (cfgRow),
        .cfg_data  (cfgData),
        .bl        (bl),
        .wl        (wl),
        .sram_reset(sramReset),
        .busy      (busy),
        .err       (err),
        .rows_done (rowsDone)
    );

    blwl_prog_ctrl #(
        .NUM_ROWS(3), .NUM_COLS(4), .SETUP_CYCLES(1), .WL_PULSE_CYCLES(2), .CLR_CYCLES(2)
    ) dut3 (
        .prog_clk  (clk),
        .reset_n   (resetN),
        .clr_req   (1'b0),
        .cfg_valid (cfgValid3),
        .cfg_ready (cfgReady3),
        .cfg_row   (cfgRow3),
        .cfg_data  (cfgData),
        .bl        (bl3),
        .wl        (wl3),
        .sram_reset(sramReset3),
        .busy      (busy3),
        .err       (err3),
        .rows_done (rowsDone3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] row, input logic [3:0] data,
                                 input logic clr);
        cfgValid = valid;
        cfgRow   = row;
        cfgData  = data;
        clrReq   = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Array-safety invariants, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (resetN === 1'b1) begin
            checkOutput("inv_onehot0_wl", {31'd0, $onehot0(wl)}, 32'd1);
            checkOutput("inv_no_reset_with_wl", {31'd0, sramReset & (|wl)}, 32'd0);
            if (|wl) begin
                checkOutput("inv_bl_stable_under_wl", {28'd0, bl}, {28'd0, prevBl});
            end
        end
        prevBl <= bl;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rowData[0] = 4'b0011;
        rowData[1] = 4'b1100;
        rowData[2] = 4'b0110;
        rowData[3] = 4'b1001;
        resetN    = 1'b0;
        cfgValid3 = 1'b0;
        cfgRow3   = 2'd0;
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0);

        // Reset held for two edges
        tick();
        tick();
        checkOutput("rst_bl", {28'd0, bl}, 32'd0);
        checkOutput("rst_wl", {28'd0, wl}, 32'd0);
        checkOutput("rst_sram_reset", {31'd0, sramReset}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_rows_done", {29'd0, rowsDone}, 32'd0);
        resetN = 1'b1;
        tick();
        checkOutput("rst_cfg_ready", {31'd0, cfgReady}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);

        // Single write, row 2 data 1010
        applyStimulus(1'b1, 2'd2, 4'b1010, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0);
        checkOutput("w2_setup_bl", {28'd0, bl}, 32'hA);
        checkOutput("w2_setup_wl", {28'd0, wl}, 32'h0);
        checkOutput("w2_setup_ready", {31'd0, cfgReady}, 32'd0);
        checkOutput("w2_setup_busy", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("w2_pulse1_wl", {28'd0, wl}, 32'h4);
        checkOutput("w2_pulse1_bl", {28'd0, bl}, 32'hA);
        tick();
        checkOutput("w2_pulse2_wl", {28'd0, wl}, 32'h4);
        tick();
        checkOutput("w2_hold_wl", {28'd0, wl}, 32'h0);
        checkOutput("w2_hold_bl", {28'd0, bl}, 32'hA);
        checkOutput("w2_hold_ready", {31'd0, cfgReady}, 32'd0);
        tick();
        checkOutput("w2_idle_bl", {28'd0, bl}, 32'h0);
        checkOutput("w2_idle_ready", {31'd0, cfgReady}, 32'd1);
        checkOutput("w2_rows_done", {29'd0, rowsDone}, 32'd1);

        // Clear and write together: clear wins, word waits
        applyStimulus(1'b1, 2'd1, 4'b0110, 1'b1);
        checkOutput("clr_ready_blocked", {31'd0, cfgReady}, 32'd0);
        tick();
        applyStimulus(1'b1, 2'd1, 4'b0110, 1'b0);
        checkOutput("clr_c1_sram_reset", {31'd0, sramReset}, 32'd1);
        checkOutput("clr_c1_rows_done", {29'd0, rowsDone}, 32'd0);
        checkOutput("clr_c1_bl", {28'd0, bl}, 32'h0);
        checkOutput("clr_c1_ready", {31'd0, cfgReady}, 32'd0);
        tick();
        checkOutput("clr_c2_sram_reset", {31'd0, sramReset}, 32'd1);
        tick();
        checkOutput("clr_done_sram_reset", {31'd0, sramReset}, 32'd0);
        checkOutput("clr_done_ready", {31'd0, cfgReady}, 32'd1);
        checkOutput("clr_done_bl", {28'd0, bl}, 32'h0);
        tick();
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0);
        checkOutput("clr_late_accept_bl", {28'd0, bl}, 32'h6);
        tick();
        checkOutput("clr_late_accept_wl", {28'd0, wl}, 32'h2);
        tick();
        tick();
        tick();
        checkOutput("clr_late_rows_done", {29'd0, rowsDone}, 32'd1);

        // Out-of-range row on the 3-row instance
        cfgValid3 = 1'b1;
        cfgRow3   = 2'd3;
        #1;
        checkOutput("oor_ready_before", {31'd0, cfgReady3}, 32'd1);
        tick();
        checkOutput("oor_err", {31'd0, err3}, 32'd1);
        checkOutput("oor_busy", {31'd0, busy3}, 32'd0);
        checkOutput("oor_ready_after", {31'd0, cfgReady3}, 32'd1);
        tick();
        cfgValid3 = 1'b0;
        checkOutput("oor_wl", {29'd0, wl3}, 32'd0);
        checkOutput("oor_bl", {28'd0, bl3}, 32'd0);
        checkOutput("oor_rows_done", {29'd0, rowsDone3}, 32'd0);
        tick();
        checkOutput("oor_err_sticky", {31'd0, err3}, 32'd1);

        // Reset in the middle of a WL pulse
        applyStimulus(1'b1, 2'd1, 4'b0101, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0);
        tick();
        checkOutput("midrst_pulse_wl", {28'd0, wl}, 32'h2);
        resetN = 1'b0;
        tick();
        checkOutput("midrst_wl", {28'd0, wl}, 32'h0);
        checkOutput("midrst_bl", {28'd0, bl}, 32'h0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_rows_done", {29'd0, rowsDone}, 32'd0);
        resetN = 1'b1;
        tick();
        checkOutput("midrst_ready", {31'd0, cfgReady}, 32'd1);
        checkOutput("midrst_idle_wl", {28'd0, wl}, 32'h0);

        // Back-to-back rows 0..3 with valid held high
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b1, 2'(r), rowData[r], 1'b0);
            tick();
            checkOutput($sformatf("b2b%0d_setup_bl", r), {28'd0, bl}, {28'd0, rowData[r]});
            checkOutput($sformatf("b2b%0d_setup_wl", r), {28'd0, wl}, 32'h0);
            tick();
            checkOutput($sformatf("b2b%0d_pulse1_wl", r), {28'd0, wl}, 32'd1 << r);
            tick();
            checkOutput($sformatf("b2b%0d_pulse2_wl", r), {28'd0, wl}, 32'd1 << r);
            tick();
            checkOutput($sformatf("b2b%0d_hold_wl", r), {28'd0, wl}, 32'h0);
            checkOutput($sformatf("b2b%0d_hold_bl", r), {28'd0, bl}, {28'd0, rowData[r]});
            tick();
            checkOutput($sformatf("b2b%0d_idle_bl", r), {28'd0, bl}, 32'h0);
            checkOutput($sformatf("b2b%0d_idle_ready", r), {31'd0, cfgReady}, 32'd1);
            checkOutput($sformatf("b2b%0d_rows_done", r), {29'd0, rowsDone}, 32'(r + 1));
        end
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0);
        tick();
        checkOutput("b2b_final_rows_done", {29'd0, rowsDone}, 32'd4);
        checkOutput("b2b_final_busy", {31'd0, busy}, 32'd0);
        checkOutput("b2b_final_err", {31'd0, err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
